// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: two-entry skid buffer on every channel, no comb paths.
// Optional macro AXI4_REG_SLICE_RD_PIPE_EN registers AR/R; otherwise they are wires.
module axi4_reg_slice_skid #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e       state_q;
    logic         rdy_q;
    logic         vld_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         push;
    logic         pop;

    assign push       = up_valid_i && rdy_q;
    assign pop        = vld_q && dn_ready_i;
    assign up_ready_o = rdy_q;
    assign dn_valid_o = vld_q;
    assign dn_data_o  = main_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    rdy_q <= 1'b1;
                    if (push) begin
                        main_q  <= up_data_i;
                        vld_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_q  <= up_data_i;
                        rdy_q   <= 1'b0;
                        state_q <= TWO;
                    end else if (pop && !push) begin
                        vld_q   <= 1'b0;
                        state_q <= EMPTY;
                    end else if (push && pop) begin
                        main_q  <= up_data_i;
                    end
                end
                TWO: begin
                    // READY is low here, so only a drain can happen
                    if (pop) begin
                        main_q  <= skid_q;
                        rdy_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

module axi4_reg_slice #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [AXI4_ID_WIDTH-1:0]      t_AWID,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] t_AWADDR,
    input  logic [7:0]                    t_AWLEN,
    input  logic [2:0]                    t_AWSIZE,
    input  logic [1:0]                    t_AWBURST,
    input  logic                          t_AWLOCK,
    input  logic [3:0]                    t_AWCACHE,
    input  logic [2:0]                    t_AWPROT,
    input  logic [3:0]                    t_AWQOS,
    input  logic [3:0]                    t_AWREGION,
    input  logic                          t_AWVALID,
    output logic                          t_AWREADY,
    input  logic [AXI4_DATA_WIDTH-1:0]    t_WDATA,
    input  logic [AXI4_DATA_WIDTH/8-1:0]  t_WSTRB,
    input  logic                          t_WLAST,
    input  logic                          t_WVALID,
    output logic                          t_WREADY,
    output logic [AXI4_ID_WIDTH-1:0]      t_BID,
    output logic [1:0]                    t_BRESP,
    output logic                          t_BVALID,
    input  logic                          t_BREADY,
    input  logic [AXI4_ID_WIDTH-1:0]      t_ARID,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] t_ARADDR,
    input  logic [7:0]                    t_ARLEN,
    input  logic [2:0]                    t_ARSIZE,
    input  logic [1:0]                    t_ARBURST,
    input  logic                          t_ARLOCK,
    input  logic [3:0]                    t_ARCACHE,
    input  logic [2:0]                    t_ARPROT,
    input  logic [3:0]                    t_ARQOS,
    input  logic [3:0]                    t_ARREGION,
    input  logic                          t_ARVALID,
    output logic                          t_ARREADY,
    output logic [AXI4_ID_WIDTH-1:0]      t_RID,
    output logic [AXI4_DATA_WIDTH-1:0]    t_RDATA,
    output logic [1:0]                    t_RRESP,
    output logic                          t_RLAST,
    output logic                          t_RVALID,
    input  logic                          t_RREADY,
    output logic [AXI4_ID_WIDTH-1:0]      i_AWID,
    output logic [AXI4_ADDRESS_WIDTH-1:0] i_AWADDR,
    output logic [7:0]                    i_AWLEN,
    output logic [2:0]                    i_AWSIZE,
    output logic [1:0]                    i_AWBURST,
    output logic                          i_AWLOCK,
    output logic [3:0]                    i_AWCACHE,
    output logic [2:0]                    i_AWPROT,
    output logic [3:0]                    i_AWQOS,
    output logic [3:0]                    i_AWREGION,
    output logic                          i_AWVALID,
    input  logic                          i_AWREADY,
    output logic [AXI4_DATA_WIDTH-1:0]    i_WDATA,
    output logic [AXI4_DATA_WIDTH/8-1:0]  i_WSTRB,
    output logic                          i_WLAST,
    output logic                          i_WVALID,
    input  logic                          i_WREADY,
    input  logic [AXI4_ID_WIDTH-1:0]      i_BID,
    input  logic [1:0]                    i_BRESP,
    input  logic                          i_BVALID,
    output logic                          i_BREADY,
    output logic [AXI4_ID_WIDTH-1:0]      i_ARID,
    output logic [AXI4_ADDRESS_WIDTH-1:0] i_ARADDR,
    output logic [7:0]                    i_ARLEN,
    output logic [2:0]                    i_ARSIZE,
    output logic [1:0]                    i_ARBURST,
    output logic                          i_ARLOCK,
    output logic [3:0]                    i_ARCACHE,
    output logic [2:0]                    i_ARPROT,
    output logic [3:0]                    i_ARQOS,
    output logic [3:0]                    i_ARREGION,
    output logic                          i_ARVALID,
    input  logic                          i_ARREADY,
    input  logic [AXI4_ID_WIDTH-1:0]      i_RID,
    input  logic [AXI4_DATA_WIDTH-1:0]    i_RDATA,
    input  logic [1:0]                    i_RRESP,
    input  logic                          i_RLAST,
    input  logic                          i_RVALID,
    output logic                          i_RREADY
);
    localparam int AXW = AXI4_ID_WIDTH + AXI4_ADDRESS_WIDTH + 29;
    localparam int WW  = AXI4_DATA_WIDTH + AXI4_DATA_WIDTH / 8 + 1;
    localparam int BW  = AXI4_ID_WIDTH + 2;
    localparam int RW  = AXI4_ID_WIDTH + AXI4_DATA_WIDTH + 3;

    logic [AXW-1:0] aw_q;
    logic [WW-1:0]  w_q;
    logic [BW-1:0]  b_q;

    axi4_reg_slice_skid #(.W(AXW)) u_aw (
        .clock      (clock),
        .reset      (reset),
        .up_valid_i (t_AWVALID),
        .up_ready_o (t_AWREADY),
        .up_data_i  ({t_AWID, t_AWADDR, t_AWLEN, t_AWSIZE, t_AWBURST,
                      t_AWLOCK, t_AWCACHE, t_AWPROT, t_AWQOS, t_AWREGION}),
        .dn_valid_o (i_AWVALID),
        .dn_ready_i (i_AWREADY),
        .dn_data_o  (aw_q)
    );
    assign {i_AWID, i_AWADDR, i_AWLEN, i_AWSIZE, i_AWBURST,
            i_AWLOCK, i_AWCACHE, i_AWPROT, i_AWQOS, i_AWREGION} = aw_q;

    axi4_reg_slice_skid #(.W(WW)) u_w (
        .clock      (clock),
        .reset      (reset),
        .up_valid_i (t_WVALID),
        .up_ready_o (t_WREADY),
        .up_data_i  ({t_WDATA, t_WSTRB, t_WLAST}),
        .dn_valid_o (i_WVALID),
        .dn_ready_i (i_WREADY),
        .dn_data_o  (w_q)
    );
    assign {i_WDATA, i_WSTRB, i_WLAST} = w_q;

    axi4_reg_slice_skid #(.W(BW)) u_b (
        .clock      (clock),
        .reset      (reset),
        .up_valid_i (i_BVALID),
        .up_ready_o (i_BREADY),
        .up_data_i  ({i_BID, i_BRESP}),
        .dn_valid_o (t_BVALID),
        .dn_ready_i (t_BREADY),
        .dn_data_o  (b_q)
    );
    assign {t_BID, t_BRESP} = b_q;

`ifdef AXI4_REG_SLICE_RD_PIPE_EN
    logic [AXW-1:0] ar_q;
    logic [RW-1:0]  r_q;

    axi4_reg_slice_skid #(.W(AXW)) u_ar (
        .clock      (clock),
        .reset      (reset),
        .up_valid_i (t_ARVALID),
        .up_ready_o (t_ARREADY),
        .up_data_i  ({t_ARID, t_ARADDR, t_ARLEN, t_ARSIZE, t_ARBURST,
                      t_ARLOCK, t_ARCACHE, t_ARPROT, t_ARQOS, t_ARREGION}),
        .dn_valid_o (i_ARVALID),
        .dn_ready_i (i_ARREADY),
        .dn_data_o  (ar_q)
    );
    assign {i_ARID, i_ARADDR, i_ARLEN, i_ARSIZE, i_ARBURST,
            i_ARLOCK, i_ARCACHE, i_ARPROT, i_ARQOS, i_ARREGION} = ar_q;

    axi4_reg_slice_skid #(.W(RW)) u_r (
        .clock      (clock),
        .reset      (reset),
        .up_valid_i (i_RVALID),
        .up_ready_o (i_RREADY),
        .up_data_i  ({i_RID, i_RDATA, i_RRESP, i_RLAST}),
        .dn_valid_o (t_RVALID),
        .dn_ready_i (t_RREADY),
        .dn_data_o  (r_q)
    );
    assign {t_RID, t_RDATA, t_RRESP, t_RLAST} = r_q;
`else
    // Read path bypassed: zero latency, READY/VALID combinational
    assign {i_ARID, i_ARADDR, i_ARLEN, i_ARSIZE, i_ARBURST,
            i_ARLOCK, i_ARCACHE, i_ARPROT, i_ARQOS, i_ARREGION} =
           {t_ARID, t_ARADDR, t_ARLEN, t_ARSIZE, t_ARBURST,
            t_ARLOCK, t_ARCACHE, t_ARPROT, t_ARQOS, t_ARREGION};
    assign i_ARVALID = t_ARVALID;
    assign t_ARREADY = i_ARREADY;
    assign {t_RID, t_RDATA, t_RRESP, t_RLAST} = {i_RID, i_RDATA, i_RRESP, i_RLAST};
    assign t_RVALID  = i_RVALID;
    assign i_RREADY  = t_RREADY;
`endif
endmodule

// File: tb/tb_axi4_reg_slice.sv
// Directed bench for axi4_reg_slice: W-channel vector table plus AW/B/AR/R
// and reset sequences.
module tb_axi4_reg_slice;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  t_AWID, t_ARID, t_BID, t_RID, i_AWID, i_ARID, i_BID, i_RID;
    logic [31:0] t_AWADDR, t_ARADDR, i_AWADDR, i_ARADDR;
    logic [7:0]  t_AWLEN, t_ARLEN, i_AWLEN, i_ARLEN;
    logic [2:0]  t_AWSIZE, t_ARSIZE, i_AWSIZE, i_ARSIZE;
    logic [1:0]  t_AWBURST, t_ARBURST, i_AWBURST, i_ARBURST;
    logic        t_AWLOCK, t_ARLOCK, i_AWLOCK, i_ARLOCK;
    logic [3:0]  t_AWCACHE, t_ARCACHE, i_AWCACHE, i_ARCACHE;
    logic [2:0]  t_AWPROT, t_ARPROT, i_AWPROT, i_ARPROT;
    logic [3:0]  t_AWQOS, t_ARQOS, i_AWQOS, i_ARQOS;
    logic [3:0]  t_AWREGION, t_ARREGION, i_AWREGION, i_ARREGION;
    logic        t_AWVALID, t_AWREADY, i_AWVALID, i_AWREADY;
    logic        t_ARVALID, t_ARREADY, i_ARVALID, i_ARREADY;
    logic [31:0] t_WDATA, i_WDATA, t_RDATA, i_RDATA;
    logic [3:0]  t_WSTRB, i_WSTRB;
    logic        t_WLAST, i_WLAST, t_WVALID, t_WREADY, i_WVALID, i_WREADY;
    logic [1:0]  t_BRESP, i_BRESP, t_RRESP, i_RRESP;
    logic        t_BVALID, t_BREADY, i_BVALID, i_BREADY;
    logic        t_RLAST, i_RLAST, t_RVALID, t_RREADY, i_RVALID, i_RREADY;

    int n_vec = 0;
    int n_bad = 0;

    axi4_reg_slice dut (
        .clock(clock), .reset(reset),
        .t_AWID(t_AWID), .t_AWADDR(t_AWADDR), .t_AWLEN(t_AWLEN),
        .t_AWSIZE(t_AWSIZE), .t_AWBURST(t_AWBURST), .t_AWLOCK(t_AWLOCK),
        .t_AWCACHE(t_AWCACHE), .t_AWPROT(t_AWPROT), .t_AWQOS(t_AWQOS),
        .t_AWREGION(t_AWREGION), .t_AWVALID(t_AWVALID), .t_AWREADY(t_AWREADY),
        .t_WDATA(t_WDATA), .t_WSTRB(t_WSTRB), .t_WLAST(t_WLAST),
        .t_WVALID(t_WVALID), .t_WREADY(t_WREADY),
        .t_BID(t_BID), .t_BRESP(t_BRESP), .t_BVALID(t_BVALID), .t_BREADY(t_BREADY),
        .t_ARID(t_ARID), .t_ARADDR(t_ARADDR), .t_ARLEN(t_ARLEN),
        .t_ARSIZE(t_ARSIZE), .t_ARBURST(t_ARBURST), .t_ARLOCK(t_ARLOCK),
        .t_ARCACHE(t_ARCACHE), .t_ARPROT(t_ARPROT), .t_ARQOS(t_ARQOS),
        .t_ARREGION(t_ARREGION), .t_ARVALID(t_ARVALID), .t_ARREADY(t_ARREADY),
        .t_RID(t_RID), .t_RDATA(t_RDATA), .t_RRESP(t_RRESP), .t_RLAST(t_RLAST),
        .t_RVALID(t_RVALID), .t_RREADY(t_RREADY),
        .i_AWID(i_AWID), .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN),
        .i_AWSIZE(i_AWSIZE), .i_AWBURST(i_AWBURST), .i_AWLOCK(i_AWLOCK),
        .i_AWCACHE(i_AWCACHE), .i_AWPROT(i_AWPROT), .i_AWQOS(i_AWQOS),
        .i_AWREGION(i_AWREGION), .i_AWVALID(i_AWVALID), .i_AWREADY(i_AWREADY),
        .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WLAST(i_WLAST),
        .i_WVALID(i_WVALID), .i_WREADY(i_WREADY),
        .i_BID(i_BID), .i_BRESP(i_BRESP), .i_BVALID(i_BVALID), .i_BREADY(i_BREADY),
        .i_ARID(i_ARID), .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN),
        .i_ARSIZE(i_ARSIZE), .i_ARBURST(i_ARBURST), .i_ARLOCK(i_ARLOCK),
        .i_ARCACHE(i_ARCACHE), .i_ARPROT(i_ARPROT), .i_ARQOS(i_ARQOS),
        .i_ARREGION(i_ARREGION), .i_ARVALID(i_ARVALID), .i_ARREADY(i_ARREADY),
        .i_RID(i_RID), .i_RDATA(i_RDATA), .i_RRESP(i_RRESP), .i_RLAST(i_RLAST),
        .i_RVALID(i_RVALID), .i_RREADY(i_RREADY)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Read channels: registered when the pipe macro is on, wires otherwise
    task automatic rd_settle;
`ifdef AXI4_REG_SLICE_RD_PIPE_EN
        step();
`else
        #1;
`endif
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wvalid;
        logic [31:0] wdata;
        logic        wlast;
        logic        iwready;
        logic        exp_twready;
        logic        exp_iwvalid;
        logic [31:0] exp_iwdata;
        logic        exp_iwlast;
    } wvec_t;

    wvec_t tbl[9];

    initial begin
        tbl[0] = '{1, 32'h11111111, 0, 1, 1, 0, 32'h0,        0};
        tbl[1] = '{1, 32'h22222222, 0, 1, 1, 1, 32'h11111111, 0};
        tbl[2] = '{1, 32'h33333333, 0, 0, 1, 1, 32'h22222222, 0};
        tbl[3] = '{1, 32'h44444444, 1, 0, 0, 1, 32'h22222222, 0};
        tbl[4] = '{1, 32'h44444444, 1, 0, 0, 1, 32'h22222222, 0};
        tbl[5] = '{1, 32'h44444444, 1, 1, 0, 1, 32'h22222222, 0};
        tbl[6] = '{1, 32'h44444444, 1, 1, 1, 1, 32'h33333333, 0};
        tbl[7] = '{0, 32'h0,        0, 1, 1, 1, 32'h44444444, 1};
        tbl[8] = '{0, 32'h0,        0, 1, 1, 0, 32'h44444444, 1};

        reset = 1'b1;
        {t_AWID, t_AWADDR, t_AWLEN, t_AWSIZE, t_AWBURST, t_AWLOCK,
         t_AWCACHE, t_AWPROT, t_AWQOS, t_AWREGION, t_AWVALID} = '0;
        {t_ARID, t_ARADDR, t_ARLEN, t_ARSIZE, t_ARBURST, t_ARLOCK,
         t_ARCACHE, t_ARPROT, t_ARQOS, t_ARREGION, t_ARVALID} = '0;
        {t_WDATA, t_WSTRB, t_WLAST, t_WVALID} = '0;
        t_BREADY = 1'b1;
        t_RREADY = 1'b1;
        i_AWREADY = 1'b1;
        i_WREADY  = 1'b1;
        i_ARREADY = 1'b1;
        {i_BID, i_BRESP, i_BVALID} = '0;
        {i_RID, i_RDATA, i_RRESP, i_RLAST, i_RVALID} = '0;
        step();
        step();

        chk("rst_t_AWREADY", t_AWREADY, 0);
        chk("rst_t_WREADY", t_WREADY, 0);
        chk("rst_i_BREADY", i_BREADY, 0);
        chk("rst_i_WVALID", i_WVALID, 0);
        reset = 1'b0;
        #1;
        chk("rel_t_AWREADY_pre", t_AWREADY, 0);
        step();
        chk("rel_t_AWREADY", t_AWREADY, 1);
        chk("rel_i_AWVALID", i_AWVALID, 0);

        // W channel: throughput, two-beat absorb, drain
        t_WSTRB = 4'hF;
        for (int i = 0; i < 9; i++) begin
            t_WVALID = tbl[i].wvalid;
            t_WDATA  = tbl[i].wdata;
            t_WLAST  = tbl[i].wlast;
            i_WREADY = tbl[i].iwready;
            #1;
            chk($sformatf("v%0d_t_WREADY", i), t_WREADY, tbl[i].exp_twready);
            chk($sformatf("v%0d_i_WVALID", i), i_WVALID, tbl[i].exp_iwvalid);
            if (tbl[i].exp_iwvalid) begin
                chk($sformatf("v%0d_i_WDATA", i), i_WDATA, tbl[i].exp_iwdata);
                chk($sformatf("v%0d_i_WLAST", i), i_WLAST, tbl[i].exp_iwlast);
                chk($sformatf("v%0d_i_WSTRB", i), i_WSTRB, 4'hF);
            end
            step();
        end

        // AW one-cycle latency
        t_AWVALID = 1'b1;
        t_AWADDR  = 32'h100;
        t_AWLEN   = 8'd3;
        t_AWID    = 4'd7;
        t_AWBURST = 2'b01;
        #1;
        chk("aw_pre_valid", i_AWVALID, 0);
        step();
        t_AWVALID = 1'b0;
        chk("aw_valid", i_AWVALID, 1);
        chk("aw_addr", i_AWADDR, 32'h100);
        chk("aw_len", i_AWLEN, 8'd3);
        chk("aw_id", i_AWID, 4'd7);
        chk("aw_burst", i_AWBURST, 2'b01);
        step();
        chk("aw_drained", i_AWVALID, 0);

        // B one-cycle latency
        i_BVALID = 1'b1;
        i_BID    = 4'd7;
        i_BRESP  = 2'b00;
        #1;
        chk("b_pre_valid", t_BVALID, 0);
        step();
        i_BVALID = 1'b0;
        chk("b_valid", t_BVALID, 1);
        chk("b_id", t_BID, 4'd7);
        chk("b_resp", t_BRESP, 2'b00);
        step();
        chk("b_drained", t_BVALID, 0);

        // B backpressure: two beats absorbed, order kept
        t_BREADY = 1'b0;
        i_BVALID = 1'b1;
        i_BID    = 4'd1;
        i_BRESP  = 2'b10;
        step();
        i_BID = 4'd2;
        chk("bbp_ready_one", i_BREADY, 1);
        step();
        i_BVALID = 1'b0;
        chk("bbp_ready_two", i_BREADY, 0);
        chk("bbp_first_id", t_BID, 4'd1);
        step();
        chk("bbp_hold_id", t_BID, 4'd1);
        t_BREADY = 1'b1;
        step();
        chk("bbp_second_id", t_BID, 4'd2);
        chk("bbp_second_valid", t_BVALID, 1);
        chk("bbp_ready_back", i_BREADY, 1);
        step();
        chk("bbp_drained", t_BVALID, 0);

        // Read path: ARID 3 then 5, RLAST on final beat of each
        t_ARVALID = 1'b1;
        t_ARADDR  = 32'h100;
        t_ARLEN   = 8'd1;
        t_ARID    = 4'd3;
        rd_settle();
        chk("ar_valid", i_ARVALID, 1);
        chk("ar_addr", i_ARADDR, 32'h100);
        chk("ar_id", i_ARID, 4'd3);
        chk("ar_ready", t_ARREADY, 1);
        t_ARVALID = 1'b0;
        i_RVALID = 1'b1;
        i_RID = 4'd3; i_RDATA = 32'hA0A0A0A0; i_RLAST = 1'b0;
        rd_settle();
        chk("r0_id", t_RID, 4'd3);
        chk("r0_data", t_RDATA, 32'hA0A0A0A0);
        chk("r0_last", t_RLAST, 0);
        chk("r0_valid", t_RVALID, 1);
        i_RID = 4'd3; i_RDATA = 32'hA1A1A1A1; i_RLAST = 1'b1;
        step();
`ifndef AXI4_REG_SLICE_RD_PIPE_EN
        #0;
`endif
        chk("r1_id", t_RID, 4'd3);
        chk("r1_data", t_RDATA, 32'hA1A1A1A1);
        chk("r1_last", t_RLAST, 1);
        i_RID = 4'd5; i_RDATA = 32'hB0B0B0B0; i_RLAST = 1'b0;
        step();
        chk("r2_id", t_RID, 4'd5);
        chk("r2_last", t_RLAST, 0);
        i_RID = 4'd5; i_RDATA = 32'hB1B1B1B1; i_RLAST = 1'b1;
        step();
        chk("r3_id", t_RID, 4'd5);
        chk("r3_data", t_RDATA, 32'hB1B1B1B1);
        chk("r3_last", t_RLAST, 1);
        i_RVALID = 1'b0;
        step();
        step();
        chk("r_drained", t_RVALID, 0);

        // Reset mid-burst discards buffered beats
        i_WREADY = 1'b0;
        t_WVALID = 1'b1;
        t_WDATA  = 32'h55555555;
        t_WLAST  = 1'b0;
        step();
        t_WDATA = 32'h66666666;
        step();
        t_WVALID = 1'b0;
        chk("mid_buffered", i_WVALID, 1);
        reset = 1'b1;
        step();
        chk("mr_t_WREADY", t_WREADY, 0);
        chk("mr_i_WVALID", i_WVALID, 0);
        chk("mr_i_WDATA", i_WDATA, 32'h0);
        chk("mr_t_AWREADY", t_AWREADY, 0);
        chk("mr_t_BVALID", t_BVALID, 0);
        reset = 1'b0;
        i_WREADY = 1'b1;
        step();
        chk("mr_t_AWREADY_up", t_AWREADY, 1);
        chk("mr_i_WVALID_post", i_WVALID, 0);
        t_AWVALID = 1'b1;
        t_AWADDR  = 32'h200;
        t_AWID    = 4'd2;
        step();
        t_AWVALID = 1'b0;
        chk("new_aw_valid", i_AWVALID, 1);
        chk("new_aw_addr", i_AWADDR, 32'h200);
        step();
        chk("new_aw_drained", i_AWVALID, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4_reg_slice.md
# axi4_reg_slice

Full-throughput AXI4 pipeline register inserted between an AXI4 master (e.g. axi4_master_bfm) and an AXI4 slave (e.g. axi4_generic_byte_en_sram_bridge). It breaks every combinational valid/ready/payload path on all five channels using a two-entry skid buffer per channel. Payloads are unmodified and ordering is preserved per channel. The testbench topology becomes BFM -> reg slice -> bridge -> SRAM.

## Interface
- AXI4_ADDRESS_WIDTH, 32, address width of AW/AR.
- AXI4_DATA_WIDTH, 32, data width of W/R; WSTRB is AXI4_DATA_WIDTH/8.
- AXI4_ID_WIDTH, 4, width of AWID/BID/ARID/RID.
- One clock; reset is synchronous and active-high. Ports are `clock` and `reset`.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all slices.
- t_AW*  in/out  AXI4 AW bundle (ID, ADDR, LEN[7:0], SIZE[2:0], BURST[1:0], LOCK, CACHE[3:0], PROT[2:0], QOS[3:0], REGION[3:0], VALID in; READY out)  target side, from master.
- t_W*  in/out  W bundle (DATA, STRB, LAST, VALID in; READY out)  target side.
- t_B*  out/in  B bundle (ID, RESP[1:0], VALID out; READY in)  target side.
- t_AR*  in/out  AR bundle (same fields as AW)  target side.
- t_R*  out/in  R bundle (ID, DATA, RESP[1:0], LAST, VALID out; READY in)  target side.
- i_AW*, i_W*, i_AR*  out/in  mirrored bundles  initiator side, to slave.
- i_B*, i_R*  in/out  mirrored bundles  initiator side, from slave.

## Operation
- Five independent channel slices. AW, W and AR forward toward the initiator side. B and R forward toward the target side.
- Each slice is a 2-entry skid buffer: main register plus skid register, with states EMPTY, ONE, TWO.
- Push = upstream VALID && upstream READY. Pop = downstream VALID && downstream READY.
- State transitions:
  - EMPTY: push -> ONE.
  - ONE: push && !pop -> TWO; pop && !push -> EMPTY; push && pop -> ONE, with the new beat loaded into the main register.
  - TWO: pop -> ONE, with the skid register moved to main. Push cannot occur in TWO because READY is 0.
- Upstream READY is a registered output, driven directly by a flop: 1 in EMPTY/ONE, 0 in TWO. The next-state value accounts for a same-cycle pop.
- Downstream VALID is driven directly by a flop: 1 in ONE/TWO.
- Downstream payload is always the main register. It is stable while VALID && !READY.
- Slices carry no burst awareness: LAST and ID pass through untouched. Multiple outstanding transactions are limited only by the endpoints.
- Reset behaviour:
  - reset=1 forces every slice to EMPTY and every output VALID and READY to 0.
  - Payload outputs reset to 0.
  - Reset mid-burst discards all buffered beats with no completion and no error response.

## Timing
- Latency: a beat pushed at edge N is presented downstream in cycle N+1, i.e. 1 cycle per slice.
- Throughput: 1 beat/cycle sustained per channel with continuous downstream READY.
- Backpressure: when downstream READY drops, upstream READY falls one cycle later. At most 2 beats are absorbed per channel.
- Post-reset: every upstream READY rises in the cycle after the first edge with reset=0. Downstream VALID stays 0 until the first push.
- No combinational path exists from any input to any output when all slices are enabled.

## Configuration
- Macro `AXI4_REG_SLICE_RD_PIPE_EN`.
- Defined: AR and R slices are instantiated as above, giving 1-cycle latency and registered READY/VALID.
- Undefined: AR and R are pure wires between the target and initiator sides, with 0 latency and combinational READY/VALID. AW, W and B are always registered.

## Test plan
- Write burst AWLEN=3 at 0x100, data 0x11111111..0x44444444, slave always ready -> each beat appears on i_W one cycle after acceptance; 4 beats in 4 consecutive cycles; B OKAY with matching AWID returns to t_B one cycle after i_B.
- Same burst with i_WREADY held 0 for 5 cycles -> t_WREADY drops after 2 buffered beats; all 4 beats arrive in order with STRB/LAST intact; memory readback equals written data.
- Random 50% READY/VALID toggling on all channels, 200 transactions of mixed length -> zero lost, duplicated or reordered beats; payload stable while VALID && !READY.
- Reset asserted after beat 2 of a 4-beat write -> all VALID/READY 0 the next cycle; t_AWREADY=1 the cycle after reset drops; a new write to 0x200 completes normally.
- With `AXI4_REG_SLICE_RD_PIPE_EN` undefined, read ARLEN=1 from 0x100 -> i_ARVALID equals t_ARVALID in the same cycle; R data returns with 0 added latency; the write path still shows 1-cycle latency.
- Back-to-back reads with ARID 3 then 5 -> t_R returns RID 3 beats then RID 5 beats unchanged, with LAST on the final beat of each.
